uart_rx_cmd: RTL and testbench

//  UART receiver (8N1, LSB first) at the Segway command input; receiving end of the link driven by the BLE module/UART_tx.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_cmd.sv | 142 ++++++++++++++
 tb/tb_uart_rx_cmd.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit and receive paths.
//   - BAUD_CYCLES_DEF : default clk cycles per bit (50 MHz / 19200 baud)
//   - rx_state_t      : receiver frame-tracking states
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BAUD_CYCLES_DEF = 2604;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_cmd.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd
//   8N1 UART receiver, LSB first, feeding the command decoder. The serial line
//   is double-synchronised, each bit is sampled at its midpoint, and a finished
//   byte is flagged with a sticky rdy until the consumer acknowledges it.
//   A start bit that is no longer low at its midpoint is rejected as noise, and
//   a low stop bit is reported as a one-cycle framing-error pulse.
//
// Ports
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset
//   RX       in   1  serial line, idle high, asynchronous to clk
//   clr_rdy  in   1  consumer acknowledge, clears rdy
//   rx_data  out  8  last received byte, valid while rdy=1
//   rdy      out  1  sticky byte-available flag
//   frm_err  out  1  one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = BAUD_CYCLES_DEF,
  parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_CYCLES + 1);

  rx_state_t     state_q, state_d;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          start_edge;
  logic          expiry;
  logic          set_rdy;
  logic          frm_pulse;

  // Synchroniser plus one history flop for edge detection. All three reset
  // high so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source; blocking here would collapse the chain into one flop.
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A held-low line (break) produces only one edge, so the receiver does not
  // re-trigger until the line has returned high.
  assign start_edge = (state_q == IDLE) && rx_prev && !rx_s;

  // Down-counter reaching 1 means exactly N cycles have elapsed since the load.
  assign expiry    = (baud_cnt == CW'(1));
  assign set_rdy   = (state_q == STOP) && expiry &&  rx_s;
  assign frm_pulse = (state_q == STOP) && expiry && !rx_s;

  // Baud/bit counters and the data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            baud_cnt <= CW'(HALF_CYCLES);
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (expiry) baud_cnt <= CW'(BAUD_CYCLES);
          else        baud_cnt <= baud_cnt - CW'(1);
        end
        DATA: begin
          if (expiry) begin
            // LSB arrives first, so shifting right leaves it in bit 0 after 8 samples.
            shift_q  <= {rx_s, shift_q[7:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= CW'(BAUD_CYCLES);
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        STOP: begin
          if (!expiry) baud_cnt <= baud_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning the default first guarantees every path drives state_d,
    // so no latch is inferred for the paths that do not change state.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = START;
      START:   if (expiry)     state_d = rx_s ? IDLE : DATA;
      DATA:    if (expiry && bit_cnt == 4'd7) state_d = STOP;
      STOP:    if (expiry)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers. Setting rdy has priority over clearing it so a byte
  // finishing in the same cycle as an acknowledge is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= frm_pulse;
      if (set_rdy) begin
        rx_data <= shift_q;
        rdy     <= 1'b1;
      end else if (start_edge || clr_rdy) begin
        rdy     <= 1'b0;
      end
    end
  end

endmodule : uart_rx_cmd

// File: tb/tb_uart_rx_cmd.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd
//   Scoreboard bench for uart_rx_cmd. Stimulus threads push the expected event
//   (received byte or framing error) before driving the frame; a monitor pops
//   and compares whenever rdy rises or frm_err pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd;
  import uart_pkg::*;

  localparam int B   = 16;
  localparam int H   = B / 2;
  localparam int LAT = 2 + H + 9 * B;

  typedef struct packed {
    logic       is_frm;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  uart_rx_cmd #(.BAUD_CYCLES(B), .HALF_CYCLES(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives one frame starting at the next falling clock edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (B) @(negedge clk);
    end
    RX = stop_bit;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_t e;
    e.is_frm = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_frm(input logic [7:0] held);
    exp_t e;
    e.is_frm = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic wait_rdy(input string name, input int limit);
    int n;
    n = 0;
    while (!rdy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, rdy, 1'b1);
  endtask

  // Monitor: pops on every rdy rising edge or frm_err pulse.
  initial begin : monitor
    logic rdy_prev;
    logic frm_pend;
    exp_t e;
    rdy_prev = 1'b0;
    frm_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frm_pend) begin
          check("frm_err_one_cycle", frm_err, 1'b0);
          frm_pend = 1'b0;
        end else if (frm_err) begin
          frm_pend = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_frm_err", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("frm_expected_kind", 32'(e.is_frm), 32'd1);
            check("frm_rdy_low", rdy, 1'b0);
            check("frm_rx_data_held", rx_data, e.data);
          end
        end
        if (rdy && !rdy_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rdy", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("byte_expected_kind", 32'(e.is_frm), 32'd0);
            check("byte_rx_data", rx_data, e.data);
          end
        end
      end
      rdy_prev = rdy;
    end
  end

  initial begin
    int cnt;
    int diff;
    n_cmp   = 0;
    n_err   = 0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: A5 with latency measured from the RX falling edge.
    push_byte(8'hA5);
    cnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        while (!rdy && cnt < 400) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    diff = (cnt > LAT) ? cnt - LAT : LAT - cnt;
    check("t1_latency_in_window", 32'(diff <= 3), 32'd1);
    check("t1_rdy", rdy, 1'b1);
    check("t1_no_frm_err", frm_err, 1'b0);
    repeat (4) @(negedge clk);

    // 2: 'G' then 'S' back-to-back; G's start edge clears the A5 rdy,
    // clr_rdy is pulsed once G is flagged.
    push_byte(8'h47);
    push_byte(8'h53);
    fork
      begin
        send_frame(8'h47, 1'b1);
        send_frame(8'h53, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        check("t2_rdy_cleared_by_start", rdy, 1'b0);
        wait_rdy("t2_g_rdy", 400);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("t2_clr_rdy", rdy, 1'b0);
      end
    join
    wait_rdy("t2_s_rdy", 40);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    check("t2_clr_after_s", rdy, 1'b0);

    // 3: glitch shorter than half a bit is rejected, then a clean byte.
    repeat (4) @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t3_rdy_low", rdy, 1'b0);
    push_byte(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_rdy("t3_rdy", 40);

    // 4: 3C with a low stop bit reports a framing error and keeps 5A.
    repeat (4) @(negedge clk);
    push_frm(8'h5A);
    send_frame(8'h3C, 1'b0);
    repeat (B) @(negedge clk);
    check("t4_rdy_low", rdy, 1'b0);
    check("t4_rx_data_held", rx_data, 8'h5A);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;

    // 4b: put 5A back on rdy so the reset test can observe it dropping.
    push_byte(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_rdy("t4b_rdy", 40);

    // 5: reset in the middle of bit 4, then a full FF frame.
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rdy", rdy, 1'b0);
    check("t5_rst_rx_data", rx_data, 8'h00);
    check("t5_rst_frm_err", frm_err, 1'b0);
    check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_byte(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_rdy("t5_ff_rdy", 40);

    // 6: clr_rdy held through the frame, dropped only once rdy is seen,
    // so it is high in the very cycle rdy sets.
    clr_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_clr_before", rdy, 1'b0);
    push_byte(8'h00);
    fork
      send_frame(8'h00, 1'b1);
      begin
        wait_rdy("t6_rdy_set_wins", 400);
        clr_rdy = 1'b0;
      end
    join
    clr_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rdy_stays", rdy, 1'b1);
    check("t6_rx_data", rx_data, 8'h00);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_cmd
